huffman_decode: RTL and testbench

HUFFMAN_DECODE -- requirements
Module: huffman_decode

---
 rtl/huffman_decode.sv | 198 +++++++++++++++++++
 tb/tb_huffman_decode.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decode.sv
// huffman_decode
//   Table-driven canonical-style Huffman bitstream decoder.
//   Up to 8 code-table entries {sym, len, code} are loaded while IDLE.
//   In DECODE, bits are shifted MSB-first into a 7-bit accumulator. After
//   each bit, the accumulated prefix is compared against every loaded entry
//   of matching length. The lowest-index match emits its symbol one clock
//   after the final code bit. Seven bits without a match park the block
//   in ERR until dec_stop is asserted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   load_en    write {sym_in, len_in, code_in} at index tbl_cnt (IDLE only)
//   sym_in     symbol of the entry being loaded
//   len_in     code length 0..7 (0 = unused entry)
//   code_in    codeword, low len bits significant, MSB-first
//   tbl_clr    empty the table (IDLE only, wins over load_en)
//   dec_start  IDLE -> DECODE when the table is non-empty
//   dec_stop   DECODE/ERR -> IDLE, partial code discarded
//   bit_valid  bitstream bit present this cycle
//   bit_in     bitstream bit
//   sym_out    last decoded symbol (held between pulses)
//   sym_valid  one-cycle pulse when sym_out updates
//   err        high while in ERR
//   busy       high in DECODE or ERR
//   tbl_cnt    number of loaded entries 0..8
//   sym_count  symbols decoded since the last entry into DECODE
module huffman_decode (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [7:0] sym_in,
    input  logic [2:0] len_in,
    input  logic [7:0] code_in,
    input  logic       tbl_clr,
    input  logic       dec_start,
    input  logic       dec_stop,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] sym_out,
    output logic       sym_valid,
    output logic       err,
    output logic       busy,
    output logic [3:0] tbl_cnt,
    output logic [7:0] sym_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t     state_q, state_d;

    logic [7:0] tbl_sym_q  [8];
    logic [7:0] tbl_sym_d  [8];
    logic [2:0] tbl_len_q  [8];
    logic [2:0] tbl_len_d  [8];
    logic [7:0] tbl_code_q [8];
    logic [7:0] tbl_code_d [8];
    logic [3:0] tbl_cnt_q, tbl_cnt_d;

    logic [6:0] acc_q, acc_d;
    logic [2:0] n_q, n_d;
    logic [7:0] sym_out_q, sym_out_d;
    logic       sym_valid_q, sym_valid_d;
    logic [7:0] sym_count_q, sym_count_d;

    // Accumulator and count as they would be after taking this cycle's bit.
    logic [6:0] acc_nxt;
    logic [2:0] n_nxt;
    logic       hit;
    logic [7:0] hit_sym;

    assign acc_nxt = {acc_q[5:0], bit_in};
    assign n_nxt   = n_q + 3'd1;

    // Priority match: the first eligible entry in index order wins, which
    // resolves tables that are not prefix-free.
    always_comb begin
        hit     = 1'b0;
        hit_sym = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!hit && (i[3:0] < tbl_cnt_q) &&
                (tbl_len_q[i[2:0]] != 3'd0) &&
                (tbl_len_q[i[2:0]] == n_nxt) &&
                (((tbl_code_q[i[2:0]] ^ {1'b0, acc_nxt}) &
                  ~(8'hFF << tbl_len_q[i[2:0]])) == 8'h00)) begin
                hit     = 1'b1;
                hit_sym = tbl_sym_q[i[2:0]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tbl_sym_d   = tbl_sym_q;
        tbl_len_d   = tbl_len_q;
        tbl_code_d  = tbl_code_q;
        tbl_cnt_d   = tbl_cnt_q;
        acc_d       = acc_q;
        n_d         = n_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        sym_count_d = sym_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tbl_clr) begin
                    tbl_cnt_d = '0;
                end else if (load_en && (tbl_cnt_q != 4'd8)) begin
                    tbl_sym_d[tbl_cnt_q[2:0]]  = sym_in;
                    tbl_len_d[tbl_cnt_q[2:0]]  = len_in;
                    tbl_code_d[tbl_cnt_q[2:0]] = code_in;
                    tbl_cnt_d                  = tbl_cnt_q + 4'd1;
                end
                // Start qualifies on the post-write count so a same-cycle
                // load lands before decoding begins.
                if (dec_start && (tbl_cnt_d != 4'd0)) begin
                    state_d     = ST_DECODE;
                    sym_count_d = '0;
                    acc_d       = '0;
                    n_d         = '0;
                end
            end

            ST_DECODE: begin
                if (dec_stop) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    n_d     = '0;
                end else if (bit_valid) begin
                    if (hit) begin
                        sym_out_d   = hit_sym;
                        sym_valid_d = 1'b1;
                        sym_count_d = sym_count_q + 8'd1;
                        acc_d       = '0;
                        n_d         = '0;
                    end else if (n_nxt == 3'd7) begin
                        state_d = ST_ERR;
                        acc_d   = '0;
                        n_d     = '0;
                    end else begin
                        acc_d = acc_nxt;
                        n_d   = n_nxt;
                    end
                end
            end

            ST_ERR: begin
                if (dec_stop) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
                tbl_sym_q[i]  <= '0;
                tbl_len_q[i]  <= '0;
                tbl_code_q[i] <= '0;
            end
            tbl_cnt_q   <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tbl_sym_q   <= tbl_sym_d;
            tbl_len_q   <= tbl_len_d;
            tbl_code_q  <= tbl_code_d;
            tbl_cnt_q   <= tbl_cnt_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign sym_count = sym_count_q;
    assign tbl_cnt   = tbl_cnt_q;
    assign err       = (state_q == ST_ERR);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_huffman_decode.sv
// tb_huffman_decode
//   Lockstep bench for huffman_decode: every clock, a behavioural model
//   (table as arrays, received prefix as an integer value plus bit count)
//   predicts all outputs, which are compared 1 ns after the rising edge.
//   Directed scenarios are followed by randomized table/bitstream rounds.
module tb_huffman_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en, tbl_clr, dec_start, dec_stop, bit_valid, bit_in;
    logic [7:0] sym_in, code_in;
    logic [2:0] len_in;
    logic [7:0] sym_out, sym_count;
    logic       sym_valid, err, busy;
    logic [3:0] tbl_cnt;

    huffman_decode dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .sym_in    (sym_in),
        .len_in    (len_in),
        .code_in   (code_in),
        .tbl_clr   (tbl_clr),
        .dec_start (dec_start),
        .dec_stop  (dec_stop),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .err       (err),
        .busy      (busy),
        .tbl_cnt   (tbl_cnt),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 idle, 1 decoding, 2 error
    int m_state;
    int m_sym [8];
    int m_len [8];
    int m_code[8];
    int m_cnt, m_val, m_n, m_out, m_valid, m_count;

    function automatic void model_reset();
        m_state = 0;
        for (int k = 0; k < 8; k++) begin
            m_sym[k] = 0; m_len[k] = 0; m_code[k] = 0;
        end
        m_cnt = 0; m_val = 0; m_n = 0; m_out = 0; m_valid = 0; m_count = 0;
    endfunction

    // Index of the first loaded entry whose codeword equals the received
    // prefix, or -1.
    function automatic int lookup();
        for (int k = 0; k < m_cnt; k++) begin
            if (m_len[k] != 0 && m_len[k] == m_n &&
                (m_code[k] % (1 << m_len[k])) == m_val)
                return k;
        end
        return -1;
    endfunction

    function automatic void model_edge();
        int idx;
        m_valid = 0;
        case (m_state)
            0: begin
                if (tbl_clr) m_cnt = 0;
                else if (load_en && m_cnt < 8) begin
                    m_sym[m_cnt]  = sym_in;
                    m_len[m_cnt]  = len_in;
                    m_code[m_cnt] = code_in;
                    m_cnt++;
                end
                if (dec_start && m_cnt > 0) begin
                    m_state = 1; m_count = 0; m_val = 0; m_n = 0;
                end
            end
            1: begin
                if (dec_stop) begin
                    m_state = 0; m_val = 0; m_n = 0;
                end else if (bit_valid) begin
                    m_val = m_val * 2 + int'(bit_in);
                    m_n++;
                    idx = lookup();
                    if (idx >= 0) begin
                        m_out = m_sym[idx]; m_valid = 1;
                        m_count = (m_count + 1) % 256;
                        m_val = 0; m_n = 0;
                    end else if (m_n == 7) begin
                        m_state = 2; m_val = 0; m_n = 0;
                    end
                end
            end
            default: if (dec_stop) m_state = 0;
        endcase
    endfunction

    task automatic compare_all(input string ctx);
        check_eq({ctx, ".sym_valid"}, 32'(sym_valid), 32'(m_valid));
        check_eq({ctx, ".sym_out"},   32'(sym_out),   32'(m_out));
        check_eq({ctx, ".sym_count"}, 32'(sym_count), 32'(m_count));
        check_eq({ctx, ".tbl_cnt"},   32'(tbl_cnt),   32'(m_cnt));
        check_eq({ctx, ".err"},       32'(err),       32'(m_state == 2));
        check_eq({ctx, ".busy"},      32'(busy),      32'(m_state != 0));
    endtask

    int got_q[$];

    // One clock: inputs already driven, model steps with the edge, outputs
    // checked 1 ns later, then all pulse inputs drop.
    task automatic cyc(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ctx);
        if (sym_valid) got_q.push_back(int'(sym_out));
        load_en = 0; tbl_clr = 0; dec_start = 0; dec_stop = 0; bit_valid = 0;
    endtask

    task automatic load(input int s, input int l, input int c);
        load_en = 1; sym_in = 8'(s); len_in = 3'(l); code_in = 8'(c);
        cyc("load");
    endtask

    task automatic send_bit(input int b);
        bit_valid = 1; bit_in = 1'(b);
        cyc("bit");
    endtask

    task automatic pulse_start();  dec_start = 1; cyc("start"); endtask
    task automatic pulse_stop();   dec_stop  = 1; cyc("stop");  endtask
    task automatic pulse_clr();    tbl_clr   = 1; cyc("clr");   endtask
    task automatic idle_cyc();     cyc("idle");                 endtask

    task automatic do_reset(input string ctx);
        rst = 0;
        #1;
        model_reset();
        compare_all(ctx);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic load_main_table();
        load(55, 2, 8'h00); load(44, 2, 8'h01); load(11, 3, 8'h04);
        load(22, 3, 8'h05); load(33, 3, 8'h06); load(0, 4, 8'h0E);
        load(66, 5, 8'h1E); load(77, 5, 8'h1F);
    endtask

    initial begin
        int stream[10];
        rst = 0; load_en = 0; tbl_clr = 0; dec_start = 0; dec_stop = 0;
        bit_valid = 0; bit_in = 0; sym_in = 0; len_in = 0; code_in = 0;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1;

        // Full table decode: 00 -> 55, 11111 -> 77, then 1 0 0 -> 0x04 -> 11.
        load_main_table();
        check_eq("full_tbl_cnt", 32'(tbl_cnt), 32'd8);
        pulse_start();
        got_q.delete();
        stream = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        foreach (stream[k]) send_bit(stream[k]);
        idle_cyc();
        check_eq("full_n_syms", got_q.size(), 3);
        check_eq("full_sym0", got_q[0], 55);
        check_eq("full_sym1", got_q[1], 77);
        check_eq("full_sym2", got_q[2], 11);
        check_eq("full_count", 32'(sym_count), 32'd3);

        // Gapped bitstream 1 1 1 0 -> 0x0E -> symbol 0.
        pulse_stop();
        pulse_start();
        got_q.delete();
        foreach (stream[k]) if (k < 4) begin
            send_bit(k == 3 ? 0 : 1);
            idle_cyc(); idle_cyc();
        end
        check_eq("gap_n_syms", got_q.size(), 1);
        check_eq("gap_sym", got_q[0], 0);
        check_eq("gap_count", 32'(sym_count), 32'd1);

        // Overflow into ERR.
        pulse_stop();
        pulse_clr();
        load(55, 2, 8'h00);
        pulse_start();
        got_q.delete();
        for (int k = 0; k < 7; k++) send_bit(1);
        check_eq("ovf_err", 32'(err), 32'd1);
        for (int k = 0; k < 4; k++) send_bit(0);
        check_eq("ovf_err_held", 32'(err), 32'd1);
        check_eq("ovf_no_sym", got_q.size(), 0);
        pulse_stop();
        check_eq("ovf_stop_err", 32'(err), 32'd0);
        check_eq("ovf_stop_busy", 32'(busy), 32'd0);
        check_eq("ovf_stop_cnt", 32'(tbl_cnt), 32'd1);

        // Table overflow: 9th entry (len 1, code 1) ignored; clear; empty start.
        pulse_clr();
        load_main_table();
        load(99, 1, 8'h01);
        check_eq("tfull_cnt", 32'(tbl_cnt), 32'd8);
        pulse_start();
        got_q.delete();
        send_bit(1);
        check_eq("tfull_no_sym", got_q.size(), 0);
        pulse_stop();
        pulse_clr();
        check_eq("clr_cnt", 32'(tbl_cnt), 32'd0);
        pulse_start();
        check_eq("empty_start_busy", 32'(busy), 32'd0);

        // Non-prefix-free: lowest index wins.
        load(11, 2, 8'h02); load(22, 2, 8'h02);
        pulse_start();
        got_q.delete();
        send_bit(1); send_bit(0);
        check_eq("prio_sym", got_q[0], 11);

        // Load and start in the same cycle.
        pulse_stop();
        load_en = 1; sym_in = 8'd123; len_in = 3'd3; code_in = 8'h07; dec_start = 1;
        cyc("load_start");
        check_eq("ls_busy", 32'(busy), 32'd1);
        got_q.delete();
        send_bit(1); send_bit(1); send_bit(1);
        check_eq("ls_sym", got_q[0], 123);

        // Reset mid-decode, then load on first edge after release.
        send_bit(1); send_bit(1);
        do_reset("midreset");
        check_eq("midreset_cnt", 32'(tbl_cnt), 32'd0);
        idle_cyc();
        load(9, 1, 8'h00);
        check_eq("post_reset_load", 32'(tbl_cnt), 32'd1);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0) do_reset("rnd_reset");
            pulse_stop();
            pulse_clr();
            for (int k = 0, nl = $urandom_range(0, 9); k < nl; k++)
                load($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 255));
            pulse_start();
            for (int c = 0; c < 80; c++) begin
                bit_valid = ($urandom_range(0, 3) != 0);
                bit_in    = 1'($urandom_range(0, 1));
                dec_stop  = ($urandom_range(0, 39) == 0);
                dec_start = ($urandom_range(0, 7) == 0);
                tbl_clr   = ($urandom_range(0, 31) == 0);
                load_en   = ($urandom_range(0, 7) == 0);
                sym_in    = 8'($urandom_range(0, 255));
                len_in    = 3'($urandom_range(0, 7));
                code_in   = 8'($urandom_range(0, 255));
                cyc("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
